// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave that snapshots a fabric word on a qualified strobe and exposes DATA/STATUS/CONTROL to software.
// Optional capture timestamp at offset 0xC is built only when SIMULINK2PPC_TIMESTAMP_EN is defined.
`timescale 1ns/1ps
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'hFFFFFFFF,
    parameter logic [31:0] C_HIGHADDR   = 32'h00000000,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_data_valid,
    output logic                        user_armed
);

    localparam int unused_family_bits = $bits(C_FAMILY);

    logic        hit;
    logic        busy;
    logic        vld_p0;
    logic        rnw_p0;
    logic        be3_p0;
    logic [1:0]  off_p0;
    logic [2:0]  wbits_p0;
    logic [31:0] rd_word;
    logic [31:0] ts_word;

    logic [31:0] data_q;
    logic        valid_q;
    logic        ovf_q;
    logic        armed_q;
    logic        cont_q;
    logic [15:0] count_q;

    logic        cap;
    logic        ctl_wr;
    logic        ctl_clr;
    logic        data_rd;

    logic        unused_ok;

    function automatic logic [31:0] pack_status(input logic [15:0] cnt, input logic cont,
                                                input logic armed, input logic ovf,
                                                input logic valid);
        // OPB bit 31 is the numeric LSB, so flags sit in the low nibble and count in the top half.
        return {cnt, 12'd0, cont, armed, ovf, valid};
    endfunction

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign unused_ok  = ^{OPB_seqAddr, OPB_BE[0:C_OPB_DWIDTH/8-2], OPB_DBus[0:C_OPB_DWIDTH-4]};

    assign hit     = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign cap     = user_data_valid && armed_q;
    assign ctl_wr  = vld_p0 && !rnw_p0 && (off_p0 == 2'd2) && be3_p0;
    assign ctl_clr = ctl_wr && wbits_p0[1];
    assign data_rd = vld_p0 && rnw_p0 && (off_p0 == 2'd0);

    always_comb begin
        rd_word = '0;
        case (off_p0)
            2'd0:    rd_word = data_q;
            2'd1:    rd_word = pack_status(count_q, cont_q, armed_q, ovf_q, valid_q);
            2'd3:    rd_word = ts_word;
            default: rd_word = '0;
        endcase
    end

    // Stage p0: accept a request; busy blocks re-acceptance until select drops.
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            busy       <= 1'b0;
            vld_p0     <= 1'b0;
            rnw_p0     <= 1'b0;
            be3_p0     <= 1'b0;
            off_p0     <= 2'd0;
            wbits_p0   <= 3'd0;
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
        end else begin
            busy       <= OPB_select && (busy || hit);
            vld_p0     <= OPB_select && hit && !busy;
            rnw_p0     <= OPB_RNW;
            be3_p0     <= OPB_BE[3];
            off_p0     <= OPB_ABus[28:29];
            wbits_p0   <= {OPB_DBus[29], OPB_DBus[30], OPB_DBus[31]};
            // Stage p1: acknowledge, returning register state from before this edge's capture.
            Sl_xferAck <= vld_p0;
            Sl_DBus    <= (vld_p0 && rnw_p0) ? rd_word : '0;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            armed_q <= 1'b0;
            cont_q  <= 1'b0;
            count_q <= '0;
        end else begin
            if (cap)
                data_q <= user_data_in;

            if (ctl_clr)
                valid_q <= 1'b0;
            else if (cap)
                valid_q <= 1'b1;
            else if (data_rd)
                valid_q <= 1'b0;

            if (ctl_clr)
                ovf_q <= 1'b0;
            else if (cap && valid_q)
                ovf_q <= 1'b1;

            if (ctl_clr)
                count_q <= '0;
            else if (cap)
                count_q <= count_q + 16'd1;

            // Arm only ever sets; the one-shot capture is the only thing that disarms.
            if (ctl_wr && wbits_p0[0])
                armed_q <= 1'b1;
            else if (cap && !cont_q)
                armed_q <= 1'b0;

            if (ctl_wr)
                cont_q <= wbits_p0[2];
        end
    end

    assign user_armed = armed_q;

`ifdef SIMULINK2PPC_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_q;

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (cap)
                ts_q <= ts_cnt;
        end
    end

    assign ts_word = ts_q;
`else
    assign ts_word = '0;
`endif

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Directed plus randomized bench for the snapshot register, checked against a rule-level model.
`timescale 1ns/1ps
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h4000_0100;
    localparam logic [31:0] HIGH = 32'h4000_01FF;
`ifdef SIMULINK2PPC_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        sel;
    logic        seq;
    logic [0:31] sl_dbus;
    logic        ack, errack, retry, tout;
    logic [31:0] ud;
    logic        uv;
    logic        uarmed;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_data;
    bit          m_valid, m_ovf, m_armed, m_cont;
    int          m_count;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_snap #(
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH),
        .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_FAMILY("virtex5")
    ) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(errack), .Sl_retry(retry),
        .Sl_toutSup(tout), .user_data_in(ud), .user_data_valid(uv), .user_armed(uarmed)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        m_data = '0; m_valid = 0; m_ovf = 0; m_armed = 0; m_cont = 0; m_count = 0;
    endfunction

    // One clock edge of events: optional strobe, optional CONTROL write, optional DATA read.
    function automatic void m_apply(input bit strobe, input logic [31:0] sd, input bit wr,
                                    input logic [31:0] wd, input logic [3:0] bev, input bit drd);
        bit took = strobe && m_armed;
        bit ctl  = wr && bev[0];
        bit clr  = ctl && wd[1];
        bit was_valid = m_valid;
        bit was_cont  = m_cont;
        if (took) m_data = sd;
        m_valid = clr ? 1'b0 : (took ? 1'b1 : (drd ? 1'b0 : m_valid));
        m_ovf   = clr ? 1'b0 : (m_ovf || (took && was_valid));
        m_count = clr ? 0 : (m_count + (took ? 1 : 0)) % 65536;
        if (took && !was_cont) m_armed = 0;
        if (ctl && wd[0]) m_armed = 1;
        if (ctl) m_cont = wd[2];
    endfunction

    function automatic logic [31:0] m_expect(input int off);
        logic [15:0] c = 16'(m_count);
        case (off)
            0: return m_data;
            1: return {c, 12'd0, m_cont, m_armed, m_ovf, m_valid};
            default: return 32'h0;
        endcase
    endfunction

    task automatic strobe(input logic [31:0] sd);
        m_apply(1, sd, 0, 0, 0, 0);
        ud = sd; uv = 1'b1;
        tick();
        uv = 1'b0;
        check("armed_after_strobe", {31'd0, uarmed}, {31'd0, m_armed});
    endtask

    // Runs one OPB transfer; s_at 1/2/3 places a capture strobe on the select, ack or following edge.
    task automatic xfer(input logic [31:0] addr, input bit rd, input logic [31:0] wd,
                        input logic [3:0] bev, input int s_at, input logic [31:0] sd,
                        output logic [31:0] rdata, output int lat);
        abus = addr; rnw = rd; dbus = wd; be = bev; sel = 1'b1;
        lat = -1; rdata = '0;
        for (int i = 1; i <= 6; i++) begin
            if (i == s_at && s_at < 3) begin ud = sd; uv = 1'b1; end
            tick();
            uv = 1'b0;
            if (ack) begin lat = i; rdata = sl_dbus; break; end
            check("dbus_zero_without_ack", sl_dbus, 32'h0);
        end
        sel = 1'b0; rnw = 1'b0; dbus = '0; be = '0;
        if (s_at == 3) begin ud = sd; uv = 1'b1; end
        tick();
        uv = 1'b0;
        check("ack_single_cycle", {31'd0, ack}, 32'h0);
        check("dbus_idle", sl_dbus, 32'h0);
    endtask

    task automatic op(input bit rd, input int off, input logic [31:0] wd, input logic [3:0] bev,
                      input int s_at, input logic [31:0] sd, input string tag);
        logic [31:0] exp, got;
        int lat;
        if (s_at == 1) m_apply(1, sd, 0, 0, 0, 0);
        exp = rd ? m_expect(off) : 32'h0;
        m_apply(s_at == 2, sd, !rd && off == 2, wd, bev, rd && off == 0);
        if (s_at == 3) m_apply(1, sd, 0, 0, 0, 0);
        xfer(BASE + 32'(off * 4), rd, wd, bev, s_at, sd, got, lat);
        check({tag, "_latency"}, 32'(lat), 32'd2);
        if (!(rd && off == 3 && TS_EN)) check({tag, "_rdata"}, got, exp);
        check({tag, "_armed"}, {31'd0, uarmed}, {31'd0, m_armed});
    endtask

    task automatic read_const(input int off, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        int lat;
        xfer(BASE + 32'(off * 4), 1'b1, 0, 0, 0, 0, got, lat);
        if (off == 0) m_apply(0, 0, 0, 0, 0, 1);
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check(tag, got, exp);
    endtask

    initial begin
        logic [31:0] got, t1, t2, sd, wd;
        logic [3:0]  bev;
        int lat, acks, kind, off, s_at;

        rst_n = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
        ud = '0; uv = 1'b0;
        m_reset();
        repeat (3) tick();
        check("reset_ack", {31'd0, ack}, 32'h0);
        check("reset_dbus", sl_dbus, 32'h0);
        check("reset_armed", {31'd0, uarmed}, 32'h0);
        check("tied_outputs", {29'd0, errack, retry, tout}, 32'h0);
        rst_n = 1'b1;
        tick();

        read_const(1, 32'h0000_0000, "status_after_reset");

        // One-shot capture
        op(0, 2, 32'h1, 4'b0001, 0, 0, "arm_oneshot");
        check("armed_set", {31'd0, uarmed}, 32'h1);
        strobe(32'hDEAD_BEEF);
        check("armed_dropped", {31'd0, uarmed}, 32'h0);
        read_const(1, 32'h0001_0001, "status_one_capture");
        read_const(0, 32'hDEAD_BEEF, "data_first_read");
        read_const(0, 32'hDEAD_BEEF, "data_second_read");
        read_const(1, 32'h0001_0000, "status_valid_cleared");

        // Continuous mode with overflow, byte-enable gating, then clear
        op(0, 2, 32'h2, 4'b0001, 0, 0, "clear");
        op(0, 2, 32'h5, 4'b0001, 0, 0, "arm_cont");
        for (int i = 0; i < 3; i++) strobe($urandom);
        read_const(1, 32'h0003_000F, "status_three_caps");
        op(0, 2, 32'h2, 4'b1110, 0, 0, "clear_wrong_be");
        read_const(1, 32'h0003_000F, "status_be_ignored");
        op(0, 2, 32'h2, 4'b0001, 0, 0, "clear_keep_armed");
        read_const(1, 32'h0000_0004, "status_only_armed");

        // Capture on the same edge as a DATA read
        op(1, 0, 0, 0, 2, 32'h1234_5678, "data_read_with_capture");
        read_const(0, 32'h1234_5678, "data_after_same_edge");

        // Select held for five cycles: exactly one acknowledge
        abus = BASE + 32'h4; rnw = 1'b1; sel = 1'b1; acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack) acks++;
        end
        sel = 1'b0; rnw = 1'b0;
        tick();
        check("held_select_acks", 32'(acks), 32'd1);

        // Out-of-window addresses
        xfer(BASE - 32'h4, 1'b1, 0, 0, 0, 0, got, lat);
        check("below_window_noack", 32'(lat), 32'hFFFF_FFFF);
        xfer(HIGH + 32'h1, 1'b1, 0, 0, 0, 0, got, lat);
        check("above_window_noack", 32'(lat), 32'hFFFF_FFFF);

        // Clear and capture on the same edge
        op(0, 2, 32'h1, 4'b0001, 0, 0, "rearm");
        op(0, 2, 32'h2, 4'b0001, 2, 32'hA5A5_5A5A, "clear_with_capture");
        read_const(1, 32'h0000_0000, "status_clear_wins");
        read_const(0, 32'hA5A5_5A5A, "data_taken_despite_clear");

        // Arm write and strobe on the same edge: no capture
        op(0, 2, 32'h1, 4'b0001, 2, 32'h0BAD_F00D, "arm_with_strobe");
        read_const(1, 32'h0000_0004, "status_no_capture_on_arm");

`ifdef SIMULINK2PPC_TIMESTAMP_EN
        op(0, 2, 32'h5, 4'b0001, 0, 0, "arm_for_ts");
        strobe(32'h1111_1111);
        xfer(BASE + 32'hC, 1'b1, 0, 0, 0, 0, t1, lat);
        check("ts1_latency", 32'(lat), 32'd2);
        repeat (6) tick();
        strobe(32'h2222_2222);
        xfer(BASE + 32'hC, 1'b1, 0, 0, 0, 0, t2, lat);
        check("ts2_latency", 32'(lat), 32'd2);
        check("timestamp_delta", t2 - t1, 32'd10);
`else
        t1 = '0; t2 = '0;
        read_const(3, 32'h0000_0000, "timestamp_absent");
`endif

        // Count wraps from 0xFFFF to 0x0000
        op(0, 2, 32'h2, 4'b0001, 0, 0, "clear_for_wrap");
        op(0, 2, 32'h5, 4'b0001, 0, 0, "arm_for_wrap");
        ud = 32'hC0FF_EE00; uv = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            m_apply(1, 32'hC0FF_EE00, 0, 0, 0, 0);
            tick();
        end
        uv = 1'b0;
        read_const(1, 32'h0001_000F, "status_count_wrapped");

        // Randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 3);
            sd   = $urandom;
            s_at = $urandom_range(0, 3);
            case (kind)
                0: strobe(sd);
                1: begin
                    off = $urandom_range(0, TS_EN ? 2 : 3);
                    op(1, off, 0, 0, s_at, sd, "rand_read");
                end
                2: begin
                    wd  = {29'($urandom), 3'($urandom_range(0, 7))};
                    bev = 4'($urandom_range(0, 15));
                    op(0, 2, wd, bev, s_at, sd, "rand_ctl");
                end
                default: begin
                    off = ($urandom_range(0, 2) == 2) ? 3 : $urandom_range(0, 1);
                    op(0, off, $urandom, 4'hF, s_at, sd, "rand_discard");
                end
            endcase
        end
        read_const(1, m_expect(1), "status_after_random");

        // Reset in the middle of a transfer
        op(0, 2, 32'h5, 4'b0001, 0, 0, "arm_before_reset");
        strobe(32'h7777_7777);
        abus = BASE; rnw = 1'b1; sel = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        check("reset_aborts_ack", {31'd0, ack}, 32'h0);
        sel = 1'b0; rnw = 1'b0;
        tick();
        check("no_late_ack", {31'd0, ack}, 32'h0);
        rst_n = 1'b1;
        m_reset();
        tick();
        check("armed_after_midreset", {31'd0, uarmed}, 32'h0);
        read_const(1, 32'h0000_0000, "status_after_midreset");
        read_const(0, 32'h0000_0000, "data_after_midreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
